// File: rtl/fc_layer_stream_if.sv
// Handshake bundle for fc_layer_stream: weight/bias load stream, input beats and result vector.
// The master modport is the producer/consumer side and the slave modport is the layer itself.
interface fc_layer_stream_if #(
  parameter int OUT_NUM = 16,
  parameter int LANES   = 3,
  parameter int DATA_W  = 16,
  parameter int W_W     = 8
);
  logic                      w_valid;
  logic [W_W-1:0]            w_data;
  logic                      w_ready;
  logic                      w_done;
  logic                      i_valid;
  logic [LANES*DATA_W-1:0]   i_data;
  logic                      i_ready;
  logic                      o_valid;
  logic [OUT_NUM*DATA_W-1:0] o_data;
  logic                      o_ready;

  modport master (
    output w_valid, w_data, i_valid, i_data, o_ready,
    input  w_ready, w_done, i_ready, o_valid, o_data
  );

  modport slave (
    input  w_valid, w_data, i_valid, i_data, o_ready,
    output w_ready, w_done, i_ready, o_valid, o_data
  );
endinterface

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: loads weights/biases once, then accumulates LANES inputs per beat
// into OUT_NUM bias-preloaded accumulators and emits a requantised result vector per input vector.
module fc_layer_stream #(
  parameter int IN_NUM  = 48,
  parameter int OUT_NUM = 16,
  parameter int LANES   = 3,
  parameter int DATA_W  = 16,
  parameter int W_W     = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 8,
  parameter int RELU    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fc_layer_stream_if.slave  bus
);
  localparam int NW     = IN_NUM * OUT_NUM;
  localparam int NT     = NW + OUT_NUM;
  localparam int NB     = IN_NUM / LANES;
  localparam int WC_W   = $clog2(NT + 1);
  localparam int WA_W   = (NW > 1) ? $clog2(NW) : 1;
  localparam int BI_W   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int BC_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W-1:0] RND     = (SHIFT > 0) ? ({{(ACC_W-1){1'b0}}, 1'b1} << RND_SH) : '0;
  localparam logic signed [ACC_W-1:0] ZERO    = '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {LOAD = 2'd0, IDLE = 2'd1, ACC = 2'd2, OUT = 2'd3} state_t;

  state_t                    state_r, state_nxt_s;
  logic [WC_W-1:0]           w_cnt_r;
  logic                      w_done_r;
  logic [BC_W-1:0]           beat_cnt_r;
  logic                      o_valid_r;
  logic [OUT_NUM*DATA_W-1:0] o_data_r;
  logic signed [W_W-1:0]     weight_r [NW];
  logic signed [W_W-1:0]     bias_r [OUT_NUM];
  logic signed [ACC_W-1:0]   acc_r [OUT_NUM];
  logic signed [ACC_W-1:0]   acc_nxt_s [OUT_NUM];
  logic signed [ACC_W-1:0]   bias_load_s [OUT_NUM];
  logic                      w_take_s, w_last_s, i_ready_s, in_take_s, beat_last_s, out_take_s;

  // Round half up, shift, optional ReLU, then saturate to the output word.
  function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = (acc + RND) >>> SHIFT;
    if (RELU != 32'sd0 && r < ZERO) begin
      r = ZERO;
    end else begin
      r = r;
    end
    if (r > SAT_MAX) begin
      requant = SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      requant = SAT_MIN[DATA_W-1:0];
    end else begin
      requant = r[DATA_W-1:0];
    end
  endfunction

  assign w_take_s    = bus.w_valid & ~w_done_r;
  assign w_last_s    = w_take_s & (w_cnt_r == WC_W'(NT - 1));
  assign i_ready_s   = (state_r == IDLE) | (state_r == ACC);
  assign in_take_s   = bus.i_valid & i_ready_s;
  assign beat_last_s = (beat_cnt_r == BC_W'(NB - 1));
  assign out_take_s  = o_valid_r & bus.o_ready;

  assign bus.w_done  = w_done_r;
  assign bus.w_ready = ~w_done_r;
  assign bus.i_ready = i_ready_s;
  assign bus.o_valid = o_valid_r;
  assign bus.o_data  = o_data_r;

  // Per-neuron beat sum and bias preload; the final bias word is still on the bus when the load completes.
  always_comb begin
    for (int j = 0; j < OUT_NUM; j++) begin
      acc_nxt_s[j] = acc_r[j];
      for (int k = 0; k < LANES; k++) begin
        acc_nxt_s[j] = acc_nxt_s[j]
                     + ACC_W'($signed(bus.i_data[k*DATA_W +: DATA_W]))
                     * ACC_W'(weight_r[WA_W'(j*IN_NUM + int'(beat_cnt_r)*LANES + k)]);
      end
      if (j == OUT_NUM - 1 && w_last_s) begin
        bias_load_s[j] = ACC_W'($signed(bus.w_data)) <<< SHIFT;
      end else begin
        bias_load_s[j] = ACC_W'(bias_r[j]) <<< SHIFT;
      end
    end
  end

  // Next-state logic for LOAD -> IDLE -> ACC -> OUT -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LOAD: begin
        if (w_last_s) state_nxt_s = IDLE;
        else          state_nxt_s = LOAD;
      end
      IDLE, ACC: begin
        if (in_take_s) state_nxt_s = beat_last_s ? OUT : ACC;
        else           state_nxt_s = state_r;
      end
      OUT: begin
        if (out_take_s) state_nxt_s = IDLE;
        else            state_nxt_s = OUT;
      end
      default: state_nxt_s = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= LOAD;
    else       state_r <= state_nxt_s;
  end

  // Weight and bias storage; contents are meaningless until a full load completes.
  always_ff @(posedge i_clk) begin
    if (w_take_s) begin
      if (w_cnt_r < WC_W'(NW)) weight_r[WA_W'(w_cnt_r)] <= $signed(bus.w_data);
      else                     bias_r[BI_W'(w_cnt_r - WC_W'(NW))] <= $signed(bus.w_data);
    end
  end

  // Load progress and beat position within the current vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_cnt_r    <= '0;
      w_done_r   <= 1'b0;
      beat_cnt_r <= '0;
    end else begin
      if (w_take_s) w_cnt_r <= w_cnt_r + WC_W'(1);
      if (w_last_s) w_done_r <= 1'b1;
      if (in_take_s)       beat_cnt_r <= beat_last_s ? '0 : beat_cnt_r + BC_W'(1);
      else if (out_take_s) beat_cnt_r <= '0;
    end
  end

  // Accumulators and the held result vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_r <= 1'b0;
      o_data_r  <= '0;
      for (int j = 0; j < OUT_NUM; j++) acc_r[j] <= '0;
    end else begin
      for (int j = 0; j < OUT_NUM; j++) begin
        if (w_last_s || out_take_s) acc_r[j] <= bias_load_s[j];
        else if (in_take_s)         acc_r[j] <= acc_nxt_s[j];
      end
      if (in_take_s && beat_last_s) begin
        o_valid_r <= 1'b1;
        for (int j = 0; j < OUT_NUM; j++) o_data_r[j*DATA_W +: DATA_W] <= requant(acc_nxt_s[j]);
      end else if (out_take_s) begin
        o_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fc_layer_stream.sv
// Bench for fc_layer_stream: ReLU and passthrough instances driven in lockstep, table-driven vectors
// plus backpressure, mid-vector reset, post-load write and back-to-back sequences, with a scoreboard.
module tb_fc_layer_stream;
  localparam int IN_NUM = 48, OUT_NUM = 16, LANES = 3, DATA_W = 16, W_W = 8, ACC_W = 32, SHIFT = 8;
  localparam int NB = IN_NUM / LANES;
  localparam int NW = IN_NUM * OUT_NUM;
  localparam int NT = NW + OUT_NUM;
  localparam int IW = LANES * DATA_W;
  localparam int OW = OUT_NUM * DATA_W;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  fc_layer_stream_if #(.OUT_NUM(OUT_NUM), .LANES(LANES), .DATA_W(DATA_W), .W_W(W_W)) bus_r1 ();
  fc_layer_stream_if #(.OUT_NUM(OUT_NUM), .LANES(LANES), .DATA_W(DATA_W), .W_W(W_W)) bus_r0 ();

  fc_layer_stream #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .LANES(LANES), .DATA_W(DATA_W), .W_W(W_W),
                    .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(1))
    dut_r1 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_r1));
  fc_layer_stream #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .LANES(LANES), .DATA_W(DATA_W), .W_W(W_W),
                    .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(0))
    dut_r0 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus_r0));

  typedef struct { logic [OW-1:0] r1; logic [OW-1:0] r0; } exp_t;
  typedef struct { int wv; int w5; int b3; int x; int e0_r1; int e3_r1; int e5_r1; int e0_r0; int e5_r0; } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   wt [OUT_NUM][IN_NUM];
  int   bs [OUT_NUM];
  int   xin [IN_NUM];
  exp_t sb [$];

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int ref_neuron(input int j, input bit relu);
    longint acc, r;
    acc = longint'(bs[j]) * (longint'(1) << SHIFT);
    for (int k = 0; k < IN_NUM; k++) acc += longint'(xin[k]) * longint'(wt[j][k]);
    acc = longint'(int'(acc));
    r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  function automatic logic [OW-1:0] ref_vec(input bit relu);
    logic [OW-1:0] v;
    for (int j = 0; j < OUT_NUM; j++) v[j*DATA_W +: DATA_W] = DATA_W'(ref_neuron(j, relu));
    return v;
  endfunction

  function automatic int sl1(input int j);
    return int'($signed(bus_r1.o_data[j*DATA_W +: DATA_W]));
  endfunction

  function automatic int sl0(input int j);
    return int'($signed(bus_r0.o_data[j*DATA_W +: DATA_W]));
  endfunction

  task automatic drive_w(input logic v, input logic [W_W-1:0] d);
    bus_r1.w_valid = v; bus_r1.w_data = d;
    bus_r0.w_valid = v; bus_r0.w_data = d;
  endtask

  task automatic drive_i(input logic v, input logic [IW-1:0] d);
    bus_r1.i_valid = v; bus_r1.i_data = d;
    bus_r0.i_valid = v; bus_r0.i_data = d;
  endtask

  task automatic set_ready(input logic r);
    bus_r1.o_ready = r;
    bus_r0.o_ready = r;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive_w(1'b0, '0);
    drive_i(1'b0, '0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete();
  endtask

  task automatic set_weights(input int wv, input int w5, input int b3);
    for (int j = 0; j < OUT_NUM; j++) begin
      bs[j] = (j == 3) ? b3 : 0;
      for (int k = 0; k < IN_NUM; k++) wt[j][k] = (j == 5) ? w5 : wv;
    end
  endtask

  task automatic rand_weights();
    for (int j = 0; j < OUT_NUM; j++) begin
      bs[j] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < IN_NUM; k++) wt[j][k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < IN_NUM; k++) xin[k] = int'($urandom_range(0, 6000)) - 3000;
  endtask

  // Streams all weights then biases, one word per cycle, optionally with i_valid noise.
  task automatic load_weights(input bit noise);
    for (int n = 0; n < NT; n++) begin
      if (n < NW) drive_w(1'b1, W_W'(wt[n / IN_NUM][n % IN_NUM]));
      else        drive_w(1'b1, W_W'(bs[n - NW]));
      drive_i(noise, IW'($urandom));
      @(posedge i_clk); #1;
    end
    drive_w(1'b0, '0);
    drive_i(1'b0, '0);
    check("w_done_after_load", bus_r1.w_done, 1);
    check("w_ready_after_load", bus_r1.w_ready, 0);
    check("i_ready_after_load", bus_r1.i_ready, 1);
  endtask

  task automatic send_vector(input int nbeats, input bit push);
    exp_t          e;
    logic [IW-1:0] d;
    int            t;
    if (push) begin
      e.r1 = ref_vec(1'b1);
      e.r0 = ref_vec(1'b0);
      sb.push_back(e);
    end
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = DATA_W'(xin[b*LANES + k]);
      drive_i(1'b1, d);
      t = 0;
      @(negedge i_clk);
      while (!bus_r1.i_ready && t < 300) begin
        t++;
        @(negedge i_clk);
      end
      if (t >= 300) check("i_ready_timeout", 0, 1);
      @(posedge i_clk); #1;
    end
    drive_i(1'b0, '0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      t++;
      @(negedge i_clk);
    end
    check("scoreboard_drain", sb.size(), 0);
    @(posedge i_clk); #1;
  endtask

  // Scoreboard: compare each accepted result vector against the queued expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && bus_r1.o_valid && bus_r1.o_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        n_out++;
        check_vec("o_data_relu1", bus_r1.o_data, e.r1);
        check_vec("o_data_relu0", bus_r0.o_data, e.r0);
        check("o_valid_relu0", bus_r0.o_valid, 1);
      end
    end
  end

  initial begin
    vec_t          tbl [5];
    logic [OW-1:0] hold1, hold0;
    int            outs_before;

    tbl[0] = '{1, 1, 0, 256, 48, 48, 48, 48, 48};
    tbl[1] = '{1, 1, 2, 0, 0, 2, 0, 0, 0};
    tbl[2] = '{1, -1, 0, 256, 48, 48, 0, 48, -48};
    tbl[3] = '{127, 127, 0, 32767, 32767, 32767, 32767, 32767, 32767};
    tbl[4] = '{-128, -128, 0, 32767, 0, 0, 0, -32768, -32768};

    drive_w(1'b0, '0);
    drive_i(1'b0, '0);
    set_ready(1'b1);
    #2 i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("reset_w_done", bus_r1.w_done, 0);
    check("reset_w_ready", bus_r1.w_ready, 1);
    check("reset_i_ready", bus_r1.i_ready, 0);
    check("reset_o_valid", bus_r1.o_valid, 0);
    check_vec("reset_o_data", bus_r1.o_data, '0);
    i_rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      do_reset();
      set_weights(tbl[v].wv, tbl[v].w5, tbl[v].b3);
      for (int k = 0; k < IN_NUM; k++) xin[k] = tbl[v].x;
      load_weights(v == 0);
      send_vector(NB, 1'b1);
      @(negedge i_clk);
      check("o_valid_latency", bus_r1.o_valid, 1);
      check("tbl_n0_relu1", sl1(0), tbl[v].e0_r1);
      check("tbl_n3_relu1", sl1(3), tbl[v].e3_r1);
      check("tbl_n5_relu1", sl1(5), tbl[v].e5_r1);
      check("tbl_n0_relu0", sl0(0), tbl[v].e0_r0);
      check("tbl_n5_relu0", sl0(5), tbl[v].e5_r0);
      wait_drain();
    end

    // Backpressure: result held for 10 cycles while upstream keeps offering a beat.
    do_reset();
    rand_weights();
    load_weights(1'b0);
    rand_inputs();
    set_ready(1'b0);
    send_vector(NB, 1'b1);
    @(negedge i_clk);
    hold1 = bus_r1.o_data;
    hold0 = bus_r0.o_data;
    @(posedge i_clk); #1;
    for (int i = 0; i < 10; i++) begin
      drive_i(1'b1, IW'($urandom));
      @(negedge i_clk);
      check("stall_o_valid", bus_r1.o_valid, 1);
      check("stall_i_ready", bus_r1.i_ready, 0);
      check_vec("stall_o_data_relu1", bus_r1.o_data, hold1);
      check_vec("stall_o_data_relu0", bus_r0.o_data, hold0);
      @(posedge i_clk); #1;
    end
    drive_i(1'b0, '0);
    set_ready(1'b1);
    wait_drain();
    rand_inputs();
    send_vector(NB, 1'b1);
    wait_drain();

    // Writes after the load must not disturb the weights; then back-to-back vectors.
    for (int i = 0; i < 20; i++) begin
      drive_w(1'((i % 2) == 0), 8'h7f);
      @(posedge i_clk); #1;
    end
    drive_w(1'b0, '0);
    check("w_done_held", bus_r1.w_done, 1);
    outs_before = n_out;
    for (int v = 0; v < 3; v++) begin
      rand_inputs();
      send_vector(NB, 1'b1);
    end
    wait_drain();
    check("back_to_back_count", n_out - outs_before, 3);

    // Reset after 7 beats discards everything; reload and rerun the all-ones case.
    do_reset();
    set_weights(1, 1, 0);
    for (int k = 0; k < IN_NUM; k++) xin[k] = 256;
    load_weights(1'b0);
    send_vector(7, 1'b0);
    i_rst = 1'b1;
    #1;
    check("midrst_w_done", bus_r1.w_done, 0);
    check("midrst_w_ready", bus_r1.w_ready, 1);
    check("midrst_i_ready", bus_r1.i_ready, 0);
    check("midrst_o_valid", bus_r1.o_valid, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    sb.delete();
    load_weights(1'b0);
    send_vector(NB, 1'b1);
    @(negedge i_clk);
    check("rerun_o_valid", bus_r1.o_valid, 1);
    check("rerun_n0", sl1(0), 48);
    check("rerun_n15", sl1(15), 48);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
